// File: rtl/pcs_rx_packet_pkg.sv
// Shared constants, state encodings and payload types for the PCS receive packet stage.
// The optional false-carrier reporting is selected in pcs_rx_packet by PCS_RX_FALSE_CARRIER_EN.
package pcs_rx_packet_pkg;

  localparam int unsigned CG_W    = 10;
  localparam int unsigned OCTET_W = 8;
  localparam int unsigned STATE_N = 9;

  localparam logic SYNC_OK   = 1'b1;
  localparam logic SYNC_FAIL = 1'b0;
  localparam logic TRUE      = 1'b1;
  localparam logic FALSE     = 1'b0;

  typedef enum logic [STATE_N-1:0] {
    LINK_FAILED     = 9'b000000001,
    WAIT_FOR_K      = 9'b000000010,
    RX_K            = 9'b000000100,
    IDLE_D          = 9'b000001000,
    FALSE_CARRIER   = 9'b000010000,
    START_OF_PACKET = 9'b000100000,
    RECEIVE         = 9'b001000000,
    EOP_T           = 9'b010000000,
    EOP_R           = 9'b100000000
  } rx_state_e;

  // Code-groups in abcdeifghj order, a at bit 9; _RDN / _RDP are the two disparity columns.
  localparam logic [CG_W-1:0] CG_K28_5_RDN = 10'b0011111010;
  localparam logic [CG_W-1:0] CG_K28_5_RDP = 10'b1100000101;
  localparam logic [CG_W-1:0] CG_K27_7_RDN = 10'b1101101000;
  localparam logic [CG_W-1:0] CG_K27_7_RDP = 10'b0010010111;
  localparam logic [CG_W-1:0] CG_K29_7_RDN = 10'b1011101000;
  localparam logic [CG_W-1:0] CG_K29_7_RDP = 10'b0100010111;
  localparam logic [CG_W-1:0] CG_K23_7_RDN = 10'b1110101000;
  localparam logic [CG_W-1:0] CG_K23_7_RDP = 10'b0001010111;
  localparam logic [CG_W-1:0] CG_D5_6_RDN  = 10'b1010010110;
  localparam logic [CG_W-1:0] CG_D5_6_RDP  = 10'b1010010110;
  localparam logic [CG_W-1:0] CG_D16_2_RDN = 10'b0110110101;
  localparam logic [CG_W-1:0] CG_D16_2_RDP = 10'b1001000101;

  localparam logic [OCTET_W-1:0] OCT_K28_5 = 8'hBC;
  localparam logic [OCTET_W-1:0] OCT_K27_7 = 8'hFB;
  localparam logic [OCTET_W-1:0] OCT_K29_7 = 8'hFD;
  localparam logic [OCTET_W-1:0] OCT_K23_7 = 8'hF7;
  localparam logic [OCTET_W-1:0] OCT_D5_6  = 8'hC5;
  localparam logic [OCTET_W-1:0] OCT_D16_2 = 8'h50;

  localparam logic [OCTET_W-1:0] GMII_PREAMBLE      = 8'h55;
  localparam logic [OCTET_W-1:0] GMII_FALSE_CARRIER = 8'h0E;
  localparam logic [OCTET_W-1:0] GMII_CARRIER_EXT   = 8'h0F;
  localparam logic [OCTET_W-1:0] GMII_EXT_ERROR     = 8'h1F;

  typedef struct packed {
    logic [OCTET_W-1:0] octet;
    logic               is_k;
    logic               valid;
  } dec_t;

endpackage

// File: rtl/pcs_rx_packet_decoder_10b8b.sv
// Combinational 10b/8b lookup; accepts either disparity column and never checks running disparity.
module decoder_10b8b
  import pcs_rx_packet_pkg::*;
(
  input  logic [CG_W-1:0] code_group,
  output dec_t            dec_c
);

  logic [4:0] six;
  logic       six_ok;
  logic [2:0] four;
  logic       four_ok;

  // 6b/5b sub-block (abcdei -> EDCBA)
  always_comb begin
    six    = 5'd0;
    six_ok = 1'b1;
    case (code_group[9:4])
      6'b100111, 6'b011000: six = 5'd0;
      6'b011101, 6'b100010: six = 5'd1;
      6'b101101, 6'b010010: six = 5'd2;
      6'b110001:            six = 5'd3;
      6'b110101, 6'b001010: six = 5'd4;
      6'b101001:            six = 5'd5;
      6'b011001:            six = 5'd6;
      6'b111000, 6'b000111: six = 5'd7;
      6'b111001, 6'b000110: six = 5'd8;
      6'b100101:            six = 5'd9;
      6'b010101:            six = 5'd10;
      6'b110100:            six = 5'd11;
      6'b001101:            six = 5'd12;
      6'b101100:            six = 5'd13;
      6'b011100:            six = 5'd14;
      6'b010111, 6'b101000: six = 5'd15;
      6'b011011, 6'b100100: six = 5'd16;
      6'b100011:            six = 5'd17;
      6'b010011:            six = 5'd18;
      6'b110010:            six = 5'd19;
      6'b001011:            six = 5'd20;
      6'b101010:            six = 5'd21;
      6'b011010:            six = 5'd22;
      6'b111010, 6'b000101: six = 5'd23;
      6'b110011, 6'b001100: six = 5'd24;
      6'b100110:            six = 5'd25;
      6'b010110:            six = 5'd26;
      6'b110110, 6'b001001: six = 5'd27;
      6'b001110:            six = 5'd28;
      6'b101110, 6'b010001: six = 5'd29;
      6'b011110, 6'b100001: six = 5'd30;
      6'b101011, 6'b010100: six = 5'd31;
      default:              six_ok = 1'b0;
    endcase
  end

  // 4b/3b sub-block (fghj -> HGF), primary and alternate x.7 both accepted
  always_comb begin
    four    = 3'd0;
    four_ok = 1'b1;
    case (code_group[3:0])
      4'b1011, 4'b0100:                   four = 3'd0;
      4'b1001:                            four = 3'd1;
      4'b0101:                            four = 3'd2;
      4'b1100, 4'b0011:                   four = 3'd3;
      4'b1101, 4'b0010:                   four = 3'd4;
      4'b1010:                            four = 3'd5;
      4'b0110:                            four = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: four = 3'd7;
      default:                            four_ok = 1'b0;
    endcase
  end

  // Control code-groups override the data lookup; K23.7 shares its 6b part with D23
  always_comb begin
    dec_c = '0;
    case (code_group)
      CG_K28_5_RDN, CG_K28_5_RDP: dec_c = '{octet: OCT_K28_5, is_k: 1'b1, valid: 1'b1};
      CG_K27_7_RDN, CG_K27_7_RDP: dec_c = '{octet: OCT_K27_7, is_k: 1'b1, valid: 1'b1};
      CG_K29_7_RDN, CG_K29_7_RDP: dec_c = '{octet: OCT_K29_7, is_k: 1'b1, valid: 1'b1};
      CG_K23_7_RDN, CG_K23_7_RDP: dec_c = '{octet: OCT_K23_7, is_k: 1'b1, valid: 1'b1};
      default: begin
        dec_c.octet = {four, six};
        dec_c.is_k  = 1'b0;
        dec_c.valid = six_ok & four_ok;
      end
    endcase
  end

endmodule

// File: rtl/pcs_rx_packet.sv
// PCS receive packet stage: turns synchronized code-groups into GMII RXD/RX_DV/RX_ER, 1-cycle latency.
// Define PCS_RX_FALSE_CARRIER_EN to report false carrier (RX_ER=1, RXD=0x0E) while in FALSE_CARRIER.
module pcs_rx_packet
  import pcs_rx_packet_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CG_W-1:0]   rx_code_group,
  input  logic              rx_even,
  input  logic              sync_status,
  output logic [DATA_W-1:0] RXD,
  output logic              RX_DV,
  output logic              RX_ER,
  output logic              receiving
);

`ifdef PCS_RX_FALSE_CARRIER_EN
  localparam logic               FC_ER  = 1'b1;
  localparam logic [OCTET_W-1:0] FC_RXD = GMII_FALSE_CARRIER;
`else
  localparam logic               FC_ER  = 1'b0;
  localparam logic [OCTET_W-1:0] FC_RXD = 8'h00;
`endif

  rx_state_e state;
  dec_t      dec;

  decoder_10b8b u_decoder (
    .code_group (rx_code_group),
    .dec_c      (dec)
  );

  logic is_comma, is_sop, is_eop_t, is_ext_r, is_data, is_idle_d, k_even;

  always_comb begin
    is_comma  = dec.is_k && (dec.octet == OCT_K28_5);
    is_sop    = dec.is_k && (dec.octet == OCT_K27_7);
    is_eop_t  = dec.is_k && (dec.octet == OCT_K29_7);
    is_ext_r  = dec.is_k && (dec.octet == OCT_K23_7);
    is_data   = dec.valid && !dec.is_k;
    is_idle_d = is_data && ((dec.octet == OCT_D5_6) || (dec.octet == OCT_D16_2));
    k_even    = is_comma && rx_even;
  end

  // State and outputs together; every output defaults to idle each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LINK_FAILED;
      RXD       <= '0;
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
    end else begin
      RXD       <= '0;
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
      if (sync_status == SYNC_FAIL) begin
        state <= LINK_FAILED;
        // A frame in flight is closed with exactly one errored cycle
        if (RX_DV && (state != LINK_FAILED)) begin
          RX_DV <= 1'b1;
          RX_ER <= 1'b1;
        end
      end else begin
        case (state)
          LINK_FAILED: state <= WAIT_FOR_K;
          WAIT_FOR_K: begin
            if (k_even) state <= RX_K;
          end
          RX_K: state <= is_idle_d ? IDLE_D : WAIT_FOR_K;
          IDLE_D: begin
            if (is_comma) begin
              state <= RX_K;
            end else if (is_sop) begin
              state     <= START_OF_PACKET;
              RXD       <= DATA_W'(GMII_PREAMBLE);
              RX_DV     <= 1'b1;
              receiving <= 1'b1;
            end else begin
              state <= FALSE_CARRIER;
              RXD   <= DATA_W'(FC_RXD);
              RX_ER <= FC_ER;
            end
          end
          FALSE_CARRIER: begin
            if (k_even) begin
              state <= RX_K;
            end else begin
              RXD   <= DATA_W'(FC_RXD);
              RX_ER <= FC_ER;
            end
          end
          START_OF_PACKET, RECEIVE: begin
            if (is_data) begin
              state     <= RECEIVE;
              RXD       <= DATA_W'(dec.octet);
              RX_DV     <= 1'b1;
              receiving <= 1'b1;
            end else if (is_eop_t) begin
              state <= EOP_T;
            end else if (k_even) begin
              state <= RX_K;
              RX_DV <= 1'b1;
              RX_ER <= 1'b1;
            end else begin
              state     <= RECEIVE;
              RX_DV     <= 1'b1;
              RX_ER     <= 1'b1;
              receiving <= 1'b1;
            end
          end
          EOP_T: begin
            if (is_ext_r) begin
              state <= EOP_R;
            end else begin
              state <= WAIT_FOR_K;
              RXD   <= DATA_W'(GMII_CARRIER_EXT);
              RX_ER <= 1'b1;
            end
          end
          EOP_R: begin
            if (is_ext_r) begin
              RXD   <= DATA_W'(GMII_CARRIER_EXT);
              RX_ER <= 1'b1;
            end else if (is_comma) begin
              state <= RX_K;
            end else begin
              state <= WAIT_FOR_K;
              RXD   <= DATA_W'(GMII_EXT_ERROR);
              RX_ER <= 1'b1;
            end
          end
          default: state <= LINK_FAILED;
        endcase
      end
    end
  end

endmodule
